// File: rtl/gearbox_pkg.sv
// Shared types and constants for the 4:1 serdes gearbox.
// Optional error counter is enabled with GEARBOX_ERR_CNT_EN.
package gearbox_pkg;

  localparam int unsigned PH_W      = 2;
  localparam int unsigned LANES     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_e;

endpackage

// File: rtl/serdes_gearbox_4to1_if.sv
// Parallel-in / serial-out bus of the 4:1 gearbox; err_cnt exists only
// when GEARBOX_ERR_CNT_EN is defined.
interface serdes_gearbox_4to1_if
  import gearbox_pkg::*;
#(
  parameter int unsigned W = 8
);

  logic                  sync;
  logic [LANES*W-1:0]    din;
  logic [W-1:0]          dout;
  logic                  frame;
  logic                  locked;
  logic                  err;
`ifdef GEARBOX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0]  err_cnt;

  modport master (output sync, din, input dout, frame, locked, err, err_cnt);
  modport slave  (input sync, din, output dout, frame, locked, err, err_cnt);
`else
  modport master (output sync, din, input dout, frame, locked, err);
  modport slave  (input sync, din, output dout, frame, locked, err);
`endif

endinterface

// File: rtl/gearbox_phase_fsm.sv
// Sync phase counter and SEARCH/CHECK/LOCK state machine of the gearbox.
// Exposes next-cycle phase and lock so the top can register its lane output.
module gearbox_phase_fsm
  import gearbox_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_i,
  output logic [PH_W-1:0]      ph_nxt_c,
  output logic                 lock_nxt_c,
  output logic                 locked_o,
  output logic                 err_o
`ifdef GEARBOX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic              locked_q, err_q, err_d;
  logic              sync_good, spacing_err;

  assign sync_good   = sync_i && (ph_q == PH_LAST);
  assign spacing_err = sync_i ^ (ph_q == PH_LAST);  // early or missing

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      ph_q       <= '0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= (state_d == LOCK);
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    ph_d       = sync_i ? '0 : ph_q + PH_W'(1);
    unique case (state_q)
      SEARCH: begin
        if (sync_i) begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
      end
      CHECK: begin
        if (spacing_err) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end else if (sync_good) begin
          if (good_cnt_q == CNT_LAST) state_d = LOCK;
          else                        good_cnt_d = good_cnt_q + CNT_W'(1);
        end
      end
      LOCK: begin
        if (spacing_err) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign ph_nxt_c   = ph_d;
  assign lock_nxt_c = (state_d == LOCK);
  assign locked_o   = locked_q;
  assign err_o      = err_q;

`ifdef GEARBOX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of spacing errors, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_cnt_q <= '0;
    else if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: rtl/serdes_gearbox_4to1.sv
// 4:1 parallel-to-serial gearbox: captures a word on sync, emits one lane
// per clk while locked. GEARBOX_ERR_CNT_EN adds a saturating error counter.
module serdes_gearbox_4to1
  import gearbox_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter logic [W-1:0] IDLE    = {W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serdes_gearbox_4to1_if.slave bus
);

  logic [LANES*W-1:0] word_q, word_d;
  logic [W-1:0]       dout_q, dout_d;
  logic               frame_q, frame_d;
  logic [PH_W-1:0]    ph_nxt_c;
  logic               lock_nxt_c;
  logic [W-1:0]       lane_c [LANES];

  gearbox_phase_fsm #(
    .LOCK_CNT (LOCK_CNT)
  ) u_phase_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_i     (bus.sync),
    .ph_nxt_c   (ph_nxt_c),
    .lock_nxt_c (lock_nxt_c),
    .locked_o   (bus.locked),
    .err_o      (bus.err)
`ifdef GEARBOX_ERR_CNT_EN
    ,
    .err_cnt_o  (bus.err_cnt)
`endif
  );

  assign word_d = bus.sync ? bus.din : word_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_c[g] = word_d[g*W +: W];
  end

  // Output register holds lane[ph] of the current word, so lane0 appears
  // the cycle after its sync.
  always_comb begin
    dout_d  = IDLE;
    frame_d = 1'b0;
    if (lock_nxt_c) begin
      dout_d  = lane_c[ph_nxt_c];
      frame_d = (ph_nxt_c == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      dout_q  <= IDLE;
      frame_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      dout_q  <= dout_d;
      frame_q <= frame_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_serdes_gearbox_4to1.sv
// Scoreboard bench for serdes_gearbox_4to1 (W=8, LOCK_CNT=4, plus a
// LOCK_CNT=1 instance); err_cnt checks are built with GEARBOX_ERR_CNT_EN.
module tb_serdes_gearbox_4to1;
  import gearbox_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] IDLE_V = '0;

  typedef struct packed {
    logic [W-1:0] dout;
    logic         frame;
    logic         locked;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   exp_errs = 0;
  exp_t sb_q[$];

  serdes_gearbox_4to1_if #(.W(W)) bif ();
  serdes_gearbox_4to1_if #(.W(W)) bif1 ();

  assign bif1.sync = bif.sync;
  assign bif1.din  = bif.din;

  serdes_gearbox_4to1 #(.W(W), .LOCK_CNT(4), .IDLE(IDLE_V)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  serdes_gearbox_4to1 #(.W(W), .LOCK_CNT(1), .IDLE(IDLE_V)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk();
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("dout",   32'(bif.dout),   32'(e.dout));
    chk("frame",  32'(bif.frame),  32'(e.frame));
    chk("locked", 32'(bif.locked), 32'(e.locked));
    chk("err",    32'(bif.err),    32'(e.err));
    if (e.err) exp_errs++;
  endtask

  // Drive one sync carrying w, then gap-1 quiet cycles. st is the state the
  // design must be in after this sync; e_err marks this sync as a spacing error.
  task automatic send(input logic [31:0] w, input state_e st, input bit e_err, input int gap);
    exp_t e;
    bit   lk;
    for (int k = 1; k <= gap; k++) begin
      lk       = (st == LOCK) && (k <= 4);
      e.dout   = lk ? w[(k-1)*W +: W] : IDLE_V;
      e.frame  = lk && (k == 1);
      e.locked = lk;
      e.err    = (k == 1 && e_err) || (k == 5 && st != SEARCH);
      sb_q.push_back(e);
    end
    bif.sync = 1'b1;
    bif.din  = w;
    step();
    pop_chk();
    bif.sync = 1'b0;
    bif.din  = $urandom();
    for (int k = 2; k <= gap; k++) begin
      step();
      pop_chk();
    end
  endtask

  task automatic idle(input int n);
    exp_t e;
    e = '{dout: IDLE_V, frame: 1'b0, locked: 1'b0, err: 1'b0};
    for (int k = 0; k < n; k++) sb_q.push_back(e);
    bif.sync = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      pop_chk();
    end
  endtask

  task automatic relock(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w, CHECK, 1'b0, 4);
    send(w, LOCK, 1'b0, 4);
  endtask

  initial begin
    rst_n    = 1'b0;
    bif.sync = 1'b0;
    bif.din  = '0;
    #12;
    chk("rst_dout",   32'(bif.dout),   32'(IDLE_V));
    chk("rst_frame",  32'(bif.frame),  32'd0);
    chk("rst_locked", 32'(bif.locked), 32'd0);
    chk("rst_err",    32'(bif.err),    32'd0);
`ifdef GEARBOX_ERR_CNT_EN
    chk("rst_err_cnt", 32'(bif.err_cnt), 32'd0);
`endif
    #10;
    rst_n = 1'b1;
    idle(3);

    // Initial lock: one start sync plus four good ones.
    for (int i = 0; i < 4; i++) begin
      send(32'h44332211, CHECK, 1'b0, 4);
      if (i == 0) chk("lock1_pre",  32'(bif1.locked), 32'd0);
      if (i == 1) chk("lock1_post", 32'(bif1.locked), 32'd1);
    end
    for (int i = 0; i < 3; i++) send(32'h44332211, LOCK, 1'b0, 4);

    // Early sync (spacing 3) drops lock; five syncs to relock.
    send(32'h44332211, LOCK, 1'b0, 3);
    send(32'h55667788, SEARCH, 1'b1, 4);
    relock(32'h0d0c0b0a);

    // Missing sync (gap 8): error where ph wraps without a sync.
    send(32'h99aabbcc, LOCK, 1'b0, 8);
    relock(32'h13579bdf);

    // Changing data every sync; lanes must never mix across words.
    for (int i = 0; i < 3; i++) begin
      send(32'hA0B0C0D0, LOCK, 1'b0, 4);
      send(32'hE0F0A1B1, LOCK, 1'b0, 4);
    end
`ifdef GEARBOX_ERR_CNT_EN
    chk("err_cnt_two", 32'(bif.err_cnt), 32'(exp_errs));
`endif

    // Asynchronous reset in the middle of lane 2.
    send(32'h12345678, LOCK, 1'b0, 2);
    step();
    chk("lane2_pre_rst", 32'(bif.dout), 32'h34);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout",   32'(bif.dout),   32'(IDLE_V));
    chk("arst_frame",  32'(bif.frame),  32'd0);
    chk("arst_locked", 32'(bif.locked), 32'd0);
    #2;
    rst_n = 1'b1;
    idle(6);
`ifdef GEARBOX_ERR_CNT_EN
    chk("err_cnt_clr", 32'(bif.err_cnt), 32'd0);
`endif
    relock(32'hCAFEF00D);
    send(32'hCAFEF00D, LOCK, 1'b0, 4);

`ifdef GEARBOX_ERR_CNT_EN
    // Sync every cycle: alternating CHECK entry and early error, >300 errors.
    bif.sync = 1'b1;
    for (int i = 0; i < 700; i++) begin
      bif.din = $urandom();
      step();
    end
    chk("err_cnt_sat", 32'(bif.err_cnt), 32'd255);
    for (int i = 0; i < 20; i++) step();
    chk("err_cnt_hold", 32'(bif.err_cnt), 32'd255);
    chk("storm_locked", 32'(bif.locked), 32'd0);
    bif.sync = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("err_cnt_rst", 32'(bif.err_cnt), 32'd0);
    #2;
    rst_n = 1'b1;
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
